// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect input and decode handshake.
// Performance counter ports exist only when FETCH_PERF_EN is defined.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pc_plus4;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;
    logic [31:0] perf_flush;
`endif

    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_plus4,
`ifdef FETCH_PERF_EN
        output perf_fetched, perf_stall, perf_flush,
`endif
        input  imem_rdata, redirect_valid, redirect_target, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc, out_pc_plus4,
`ifdef FETCH_PERF_EN
        input  perf_fetched, perf_stall, perf_flush,
`endif
        output imem_rdata, redirect_valid, redirect_target, out_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC ownership, credit-limited issue to a 1-cycle memory, 2-entry output queue.
// Optional FETCH_PERF_EN adds fetched/stall/flush counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter bit          WORD_ADDR = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
);

    logic [31:0] pc_r;
    logic [31:0] tag_pc_r;
    logic        inflight_r;
    logic [1:0]  count_r;
    logic [31:0] q0_instr_r, q0_pc_r, q1_instr_r, q1_pc_r, head_pc4_r;

    logic [31:0] q0_instr_n, q0_pc_n, q1_instr_n, q1_pc_n, head_pc4_n;
    logic [1:0]  count_n;
    logic        out_valid_s, pop_s, push_s, issue_s;
    logic [2:0]  occ_s;

    // Occupancy after this cycle's pop decides whether a new request still has a queue slot.
    assign out_valid_s = (count_r != 2'd0) & ~bus.redirect_valid;
    assign pop_s       = out_valid_s & bus.out_ready;
    assign push_s      = inflight_r & ~bus.redirect_valid;
    assign occ_s       = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    assign issue_s     = rst_n & ~bus.redirect_valid & (occ_s < 3'd2);

    assign bus.imem_req     = issue_s;
    assign bus.imem_addr    = WORD_ADDR ? {2'b00, pc_r[31:2]} : pc_r;
    assign bus.out_valid    = out_valid_s;
    assign bus.out_instr    = q0_instr_r;
    assign bus.out_pc       = q0_pc_r;
    assign bus.out_pc_plus4 = head_pc4_r;

    // Queue next-state: redirect empties it, otherwise shift on pop and append the returning response.
    always_comb begin
        q0_instr_n = q0_instr_r;
        q0_pc_n    = q0_pc_r;
        q1_instr_n = q1_instr_r;
        q1_pc_n    = q1_pc_r;
        head_pc4_n = head_pc4_r;
        count_n    = count_r;
        if (bus.redirect_valid) begin
            count_n = 2'd0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        q0_instr_n = bus.imem_rdata;
                        q0_pc_n    = tag_pc_r;
                        head_pc4_n = tag_pc_r + 32'd4;
                    end else begin
                        q1_instr_n = bus.imem_rdata;
                        q1_pc_n    = tag_pc_r;
                    end
                    count_n = count_r + 2'd1;
                end
                2'b01: begin
                    q0_instr_n = q1_instr_r;
                    q0_pc_n    = q1_pc_r;
                    head_pc4_n = q1_pc_r + 32'd4;
                    count_n    = count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        q0_instr_n = bus.imem_rdata;
                        q0_pc_n    = tag_pc_r;
                        head_pc4_n = tag_pc_r + 32'd4;
                    end else begin
                        q0_instr_n = q1_instr_r;
                        q0_pc_n    = q1_pc_r;
                        head_pc4_n = q1_pc_r + 32'd4;
                        q1_instr_n = bus.imem_rdata;
                        q1_pc_n    = tag_pc_r;
                    end
                end
                default: begin
                    count_n = count_r;
                end
            endcase
        end
    end

    // PC, in-flight tracking and queue storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r       <= RESET_PC;
            tag_pc_r   <= 32'h0000_0000;
            inflight_r <= 1'b0;
            count_r    <= 2'd0;
            q0_instr_r <= 32'h0000_0000;
            q0_pc_r    <= 32'h0000_0000;
            q1_instr_r <= 32'h0000_0000;
            q1_pc_r    <= 32'h0000_0000;
            head_pc4_r <= 32'h0000_0000;
        end else begin
            if (bus.redirect_valid) begin
                pc_r <= {bus.redirect_target[31:2], 2'b00};
            end else if (issue_s) begin
                pc_r <= pc_r + 32'd4;
            end else begin
                pc_r <= pc_r;
            end
            if (issue_s) begin
                tag_pc_r <= pc_r;
            end else begin
                tag_pc_r <= tag_pc_r;
            end
            inflight_r <= issue_s;
            count_r    <= count_n;
            q0_instr_r <= q0_instr_n;
            q0_pc_r    <= q0_pc_n;
            q1_instr_r <= q1_instr_n;
            q1_pc_r    <= q1_pc_n;
            head_pc4_r <= head_pc4_n;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_r, perf_stall_r, perf_flush_r;

    assign bus.perf_fetched = perf_fetched_r;
    assign bus.perf_stall   = perf_stall_r;
    assign bus.perf_flush   = perf_flush_r;

    // Free-running wrap-around event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched_r <= 32'h0000_0000;
            perf_stall_r   <= 32'h0000_0000;
            perf_flush_r   <= 32'h0000_0000;
        end else begin
            perf_fetched_r <= perf_fetched_r + {31'd0, pop_s};
            perf_stall_r   <= perf_stall_r + {31'd0, out_valid_s & ~bus.out_ready};
            perf_flush_r   <= perf_flush_r + {31'd0, bus.redirect_valid};
        end
    end
`endif

endmodule
